// File: rtl/alu_cmd_port.sv
// Byte-serial command front end for the 8-bit alu: collects {select, A, B} frames,
// runs the ALU from registered operands and returns a registered result with a valid pulse.

module alu (
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic [3:0] ALU_Sel,
  output logic [7:0] ALU_Out,
  output logic       CarryOut
);
  logic [8:0] sum;

  assign sum      = {1'b0, A} + {1'b0, B};
  assign CarryOut = sum[8];

  // Division by zero returns all ones rather than an undefined value.
  always_comb begin
    ALU_Out = 8'h00;
    case (ALU_Sel)
      4'h0: ALU_Out = sum[7:0];
      4'h1: ALU_Out = A - B;
      4'h2: ALU_Out = A * B;
      4'h3: ALU_Out = (B == 8'h00) ? 8'hFF : A / B;
      4'h4: ALU_Out = A << 1;
      4'h5: ALU_Out = A >> 1;
      4'h6: ALU_Out = {A[6:0], A[7]};
      4'h7: ALU_Out = {A[0], A[7:1]};
      4'h8: ALU_Out = A & B;
      4'h9: ALU_Out = A | B;
      4'hA: ALU_Out = A ^ B;
      4'hB: ALU_Out = ~(A | B);
      4'hC: ALU_Out = ~(A & B);
      4'hD: ALU_Out = ~(A ^ B);
      4'hE: ALU_Out = (A > B) ? 8'h01 : 8'h00;
      4'hF: ALU_Out = (A == B) ? 8'h01 : 8'h00;
      default: ALU_Out = 8'h00;
    endcase
  end
endmodule

module alu_cmd_port #(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] din,
  input  logic       din_valid,
  output logic [7:0] dout,
  output logic       carry_out,
  output logic       dout_valid,
  output logic       busy,
  output logic       err
);
  localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {IDLE, GET_A, GET_B, EXEC, RESP} state_t;

  state_t        state_q, state_d;
  logic [3:0]    sel_q, sel_d;
  logic [7:0]    a_q, a_d, b_q, b_d;
  logic          chain_q, chain_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [7:0]    dout_q, dout_d;
  logic          carry_q, carry_d;
  logic          err_q, err_d;
  logic [7:0]    alu_out;
  logic          alu_carry;
  logic          accept;
  logic          timeout_hit;
  logic          unused_rsvd;

  assign unused_rsvd = ^din[7:5];

  alu u_alu (
    .A        (a_q),
    .B        (b_q),
    .ALU_Sel  (sel_q),
    .ALU_Out  (alu_out),
    .CarryOut (alu_carry)
  );

  assign busy        = (state_q == EXEC) || (state_q == RESP);
  assign dout_valid  = (state_q == RESP);
  assign err         = err_q;
  assign dout        = dout_q;
  assign carry_out   = carry_q;
  assign accept      = din_valid && !busy;
  // Abort on the edge that ends the TIMEOUT-th consecutive idle cycle.
  assign timeout_hit = (TIMEOUT != 0) && !din_valid && (to_cnt_q == TO_LAST);

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    a_d      = a_q;
    b_d      = b_q;
    chain_d  = chain_q;
    to_cnt_d = '0;
    dout_d   = dout_q;
    carry_d  = carry_q;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          sel_d   = din[3:0];
          chain_d = din[4];
          if (din[4]) begin
            a_d     = dout_q;
            state_d = GET_B;
          end else begin
            state_d = GET_A;
          end
        end
      end
      GET_A, GET_B: begin
        if (accept) begin
          if (state_q == GET_A) begin
            a_d     = din;
            state_d = GET_B;
          end else begin
            b_d     = din;
            state_d = EXEC;
          end
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (TIMEOUT != 0) begin
          to_cnt_d = to_cnt_q + TW'(1);
        end
      end
      EXEC: begin
        dout_d  = alu_out;
        carry_d = alu_carry;
        state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      sel_q    <= 4'h0;
      a_q      <= 8'h00;
      b_q      <= 8'h00;
      chain_q  <= 1'b0;
      to_cnt_q <= '0;
      dout_q   <= 8'h00;
      carry_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      a_q      <= a_d;
      b_q      <= b_d;
      chain_q  <= chain_d;
      to_cnt_q <= to_cnt_d;
      dout_q   <= dout_d;
      carry_q  <= carry_d;
      err_q    <= err_d;
    end
  end
endmodule

// File: tb/tb_alu_cmd_port.sv
// Directed bench for alu_cmd_port: a frame-level model predicts result, valid/busy/err
// timing, and a negedge compare process checks the DUT against it every cycle.

module tb_alu_cmd_port;
  localparam int TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] din = 8'h00;
  logic       dinValid = 1'b0;
  logic [7:0] dout;
  logic       carryOut;
  logic       doutValid;
  logic       busy;
  logic       err;

  typedef struct {
    int         cyc;
    logic [7:0] val;
    logic       carry;
  } exp_t;

  exp_t       expQ[$];
  int         errQ[$];
  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;
  logic       started = 1'b0;
  logic [7:0] mdlDout = 8'h00;
  logic       mdlCarry = 1'b0;
  logic [7:0] predDout = 8'h00;
  logic       expValid, expBusy, expErr;
  int         lastValidCyc = -1;
  int         prevValidCyc = -1;
  int         busyCnt = 0;
  int         errCnt = 0;

  alu_cmd_port #(.TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .reset      (reset),
    .din        (din),
    .din_valid  (dinValid),
    .dout       (dout),
    .carry_out  (carryOut),
    .dout_valid (doutValid),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference ALU in plain integer arithmetic; returns {carry, result}.
  function automatic logic [8:0] aluRef(input logic [3:0] sel, input logic [7:0] a, input logic [7:0] b);
    int ia, ib, r;
    ia = int'(a);
    ib = int'(b);
    case (sel)
      4'h0: r = (ia + ib) % 256;
      4'h1: r = (ia - ib + 256) % 256;
      4'h2: r = (ia * ib) % 256;
      4'h3: r = (ib == 0) ? 255 : ia / ib;
      4'h4: r = (ia * 2) % 256;
      4'h5: r = ia / 2;
      4'h6: r = (ia * 2) % 256 + ia / 128;
      4'h7: r = ia / 2 + (ia % 2) * 128;
      4'h8: r = int'(a & b);
      4'h9: r = int'(a | b);
      4'hA: r = int'(a ^ b);
      4'hB: r = 255 - int'(a | b);
      4'hC: r = 255 - int'(a & b);
      4'hD: r = 255 - int'(a ^ b);
      4'hE: r = (ia > ib) ? 1 : 0;
      default: r = (ia == ib) ? 1 : 0;
    endcase
    return {((ia + ib) > 255) ? 1'b1 : 1'b0, r[7:0]};
  endfunction

  task automatic checkOutput(input string name, input logic [8:0] act, input logic [8:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, expv, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (started && !reset) begin
      expValid = 1'b0;
      expErr   = 1'b0;
      if (expQ.size() > 0 && expQ[0].cyc == cyc) begin
        expValid = 1'b1;
        mdlDout  = expQ[0].val;
        mdlCarry = expQ[0].carry;
        void'(expQ.pop_front());
      end
      expBusy = expValid || (expQ.size() > 0 && expQ[0].cyc == cyc + 1);
      if (errQ.size() > 0 && errQ[0] == cyc) begin
        expErr = 1'b1;
        void'(errQ.pop_front());
      end
      checkOutput("dout_valid", {8'h00, doutValid}, {8'h00, expValid});
      checkOutput("busy", {8'h00, busy}, {8'h00, expBusy});
      checkOutput("err", {8'h00, err}, {8'h00, expErr});
      checkOutput("dout", {1'b0, dout}, {1'b0, mdlDout});
      checkOutput("carry_out", {8'h00, carryOut}, {8'h00, mdlCarry});
      if (doutValid) begin
        prevValidCyc = lastValidCyc;
        lastValidCyc = cyc;
      end
      if (busy) busyCnt++;
      if (err) errCnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] d);
    din      = d;
    dinValid = v;
    tick();
    dinValid = 1'b0;
  endtask

  task automatic idle(input int n);
    dinValid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic applyReset();
    reset = 1'b1;
    expQ.delete();
    errQ.delete();
    tick();
    reset    = 1'b0;
    mdlDout  = 8'h00;
    mdlCarry = 1'b0;
    predDout = 8'h00;
  endtask

  // Leaves the bench right after the B edge; the frame's EXEC cycle is next.
  task automatic sendFrame(input logic [7:0] selByte, input logic [7:0] a, input logic [7:0] b, input int gap);
    logic [8:0] r;
    applyStimulus(1'b1, selByte);
    idle(gap);
    if (!selByte[4]) begin
      applyStimulus(1'b1, a);
      idle(gap);
    end
    r = aluRef(selByte[3:0], selByte[4] ? predDout : a, b);
    expQ.push_back('{cyc + 2, r[7:0], r[8]});
    predDout = r[7:0];
    applyStimulus(1'b1, b);
  endtask

  logic [7:0] chainExp[4];
  logic       chainCarry[4];

  initial begin
    chainExp   = '{8'h80, 8'hC0, 8'h00, 8'h40};
    chainCarry = '{1'b0, 1'b0, 1'b1, 1'b0};

    tick();
    tick();
    reset   = 1'b0;
    started = 1'b1;
    checkOutput("rst_dout", {1'b0, dout}, 9'h000);
    checkOutput("rst_carry", {8'h00, carryOut}, 9'h000);
    checkOutput("rst_valid", {8'h00, doutValid}, 9'h000);
    checkOutput("rst_busy", {8'h00, busy}, 9'h000);
    checkOutput("rst_err", {8'h00, err}, 9'h000);

    busyCnt = 0;
    sendFrame(8'h00, 8'h0A, 8'h02, 0);
    idle(2);
    checkOutput("add_0A_02", {carryOut, dout}, 9'h00C);
    checkOutput("add_valid_at", lastValidCyc[8:0], 9'(cyc - 1));
    checkOutput("add_busy_cycles", busyCnt[8:0], 9'd2);

    sendFrame(8'h00, 8'hF6, 8'h0A, 0);
    idle(2);
    checkOutput("add_wrap", {carryOut, dout}, 9'h100);
    sendFrame(8'h13, 8'h00, 8'h05, 0);
    idle(2);
    checkOutput("chain_div_zero", {carryOut, dout}, 9'h000);
    sendFrame(8'h00, 8'h23, 8'h00, 0);
    idle(2);
    sendFrame(8'h13, 8'h00, 8'h05, 0);
    idle(2);
    checkOutput("chain_div_23", {carryOut, dout}, 9'h007);

    sendFrame(8'h01, 8'h30, 8'h10, 3);
    idle(2);
    checkOutput("sub_gap3", {carryOut, dout}, 9'h020);
    sendFrame(8'h08, 8'hF0, 8'h3C, TIMEOUT - 1);
    idle(2);
    checkOutput("and_gap_max", {carryOut, dout}, 9'h130);

    errCnt = 0;
    applyStimulus(1'b1, 8'h00);
    errQ.push_back(cyc + 1 + TIMEOUT);
    applyStimulus(1'b1, 8'h77);
    idle(TIMEOUT);
    checkOutput("timeout_dout_kept", {carryOut, dout}, 9'h130);
    sendFrame(8'h00, 8'h01, 8'h01, 0);
    idle(2);
    checkOutput("timeout_err_pulses", errCnt[8:0], 9'd1);
    checkOutput("after_timeout", {carryOut, dout}, 9'h002);

    sendFrame(8'h02, 8'h0C, 8'h05, 0);
    applyStimulus(1'b1, 8'hFF);
    applyStimulus(1'b1, 8'hFF);
    checkOutput("mul_with_junk", {carryOut, dout}, 9'h03C);
    sendFrame(8'h09, 8'h50, 8'h05, 0);
    idle(2);
    checkOutput("or_after_junk", {carryOut, dout}, 9'h055);

    applyStimulus(1'b1, 8'h00);
    applyStimulus(1'b1, 8'h55);
    applyReset();
    checkOutput("reset_mid_dout", {carryOut, dout}, 9'h000);
    sendFrame(8'h00, 8'h10, 8'h02, 0);
    idle(2);
    checkOutput("after_reset_mid", {carryOut, dout}, 9'h012);

    sendFrame(8'h00, 8'h20, 8'h20, 0);
    applyReset();
    checkOutput("reset_exec_dout", {carryOut, dout}, 9'h000);
    idle(3);
    sendFrame(8'h00, 8'h10, 8'h02, 0);
    idle(2);
    checkOutput("after_reset_exec", {carryOut, dout}, 9'h012);

    sendFrame(8'h00, 8'h00, 8'h40, 0);
    idle(2);
    for (int i = 0; i < 4; i++) begin
      sendFrame(8'h10, 8'h00, 8'h40, 0);
      idle(2);
      checkOutput($sformatf("chain_run_%0d", i), {carryOut, dout}, {chainCarry[i], chainExp[i]});
      if (i > 0) checkOutput($sformatf("chain_period_%0d", i), 9'(lastValidCyc - prevValidCyc), 9'd4);
    end

    idle(3);
    checkOutput("queue_drained", 9'(expQ.size() + errQ.size()), 9'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_cmd_port.md
# alu_cmd_port

Byte-serial command front end for the 8-bit `alu`. It accepts a three-byte frame (select, A, B) over an 8-bit valid-qualified input bus and drives a single internal `alu` instance from registers. It returns the registered 8-bit result and carry with a one-cycle valid pulse. The block sits between the chip's narrow input pins and the ALU, and does the job a bench does by hand: load A, B and ALU_Sel, then sample ALU_Out and CarryOut.

## Interface
- `TIMEOUT`, default 16: idle cycles allowed between bytes of a partial frame before it is abandoned; 0 disables the timeout.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `din`  in  8  command/operand byte.
- `din_valid`  in  1  `din` is offered this cycle; a byte is accepted when `din_valid`=1 and `busy`=0.
- `dout`  out  8  registered ALU result of the last completed frame.
- `carry_out`  out  1  registered ALU CarryOut of the last completed frame.
- `dout_valid`  out  1  one-cycle pulse when `dout`/`carry_out` update.
- `busy`  out  1  high in the EXEC and RESP states; input bytes are dropped while it is high.
- `err`  out  1  one-cycle pulse when a partial frame is abandoned by timeout.

## Operation
- Byte 0 (select byte):
  - `din[3:0]` = ALU_Sel.
  - `din[4]` = CHAIN: use the previous `dout` as A and skip byte 1.
  - `din[7:5]` are reserved and ignored.
- Byte 1 = A (absent when CHAIN=1). Next byte = B.
- Registers: `sel_r[3:0]`, `a_r[7:0]`, `b_r[7:0]`, `chain_r`, timeout counter `to_cnt` (width clog2(TIMEOUT+1), minimum 1).
- The `alu` instance is driven only from `a_r`, `b_r` and `sel_r`; no combinational path runs from `din` to the ALU.
- FSM states, with transitions on accepted bytes:
  - IDLE: on an accepted byte, load `sel_r` and `chain_r`. If CHAIN=1, load `a_r` from `dout` and go to GET_B; otherwise go to GET_A.
  - GET_A: on an accepted byte, load `a_r` and go to GET_B.
  - GET_B: on an accepted byte, load `b_r` and go to EXEC.
  - EXEC: the ALU settles; at the end of the cycle capture ALU_Out into `dout` and CarryOut into `carry_out`; go to RESP.
  - RESP: `dout_valid`=1 for this cycle only; go to IDLE.
- Timeout:
  - In GET_A and GET_B, `to_cnt` increments each cycle with `din_valid`=0 and clears on an accepted byte.
  - When `to_cnt` reaches TIMEOUT, go to IDLE and pulse `err`; `dout` and `carry_out` are unchanged.
  - `to_cnt` is held at 0 in the other states.
- Arithmetic: result is 8 bits. Carry comes from the ALU's 9-bit A+B, independent of select. Overflow wraps, with no saturation.
- CHAIN in the very first frame after reset uses A = 0x00, the reset value of `dout`.

## Timing
- Reset values (apply in the cycle after `reset` is sampled high):
  - state = IDLE.
  - `dout` = 0x00, `carry_out` = 0, `dout_valid` = 0, `busy` = 0, `err` = 0.
  - `sel_r`, `a_r`, `b_r`, `chain_r` and `to_cnt` all 0.
- Reset mid-frame or in EXEC/RESP discards the frame with no `dout_valid` pulse. `reset` has priority over `din_valid` in the same cycle.
- Latency: B is accepted at edge t; EXEC is the cycle after t; `dout_valid` is high in the cycle after EXEC, i.e. 2 cycles after the B edge.
- Throughput:
  - 5 cycles per frame with back-to-back bytes (3 accept cycles + EXEC + RESP).
  - 4 cycles per frame with CHAIN=1.
- Bytes may arrive with gaps of any length below TIMEOUT.
- Bytes offered during EXEC or RESP are dropped, not buffered. The source must hold off while `busy`=1.
- The next select byte may be accepted in the first IDLE cycle after RESP.
- `dout_valid` and `err` never assert in the same cycle.
- Gap boundary: a gap of exactly TIMEOUT-1 idle cycles still accepts the next byte; a gap of TIMEOUT cycles aborts the frame.

## Test plan
- Reset, then frame {0x00, 0x0A, 0x02} on consecutive cycles (select 0x00 = add):
  - `dout`=0x0C, `carry_out`=0.
  - `dout_valid` high exactly 2 cycles after B is accepted, for 1 cycle.
  - `busy` high for exactly 2 cycles.
- Frame {0x00, 0xF6, 0x0A}:
  - `dout`=0x00, `carry_out`=1 (wrap-around).
  - Then frame {0x13, 0x05} (CHAIN, select 0x03 = divide), expecting 0x00/0x05 = 0x00.
  - Then {0x00, 0x23, 0x00} followed by chained {0x13, 0x05}, expecting `dout`=0x07.
- Bytes with 3-cycle gaps and TIMEOUT=16: the frame completes normally.
  - Then select byte + A followed by 16 idle cycles: `err` pulses once, state returns to IDLE, `dout` is unchanged.
  - The next full frame {0x00, 0x01, 0x01} gives 0x02.
- `din_valid` held high through EXEC/RESP with junk 0xFF: the junk is dropped and the result is unaffected.
  - The following select byte is accepted in the first IDLE cycle.
- `reset` pulsed after byte 1, and separately during EXEC:
  - No `dout_valid`, and `dout` reads 0x00.
  - A subsequent frame {0x00, 0x10, 0x02} gives 0x12.
- Chained run of 4 frames, each CHAIN add with B=0x40, starting from A=0x40:
  - `dout` sequence 0x80, 0xC0, 0x00 (`carry_out`=1), 0x40.
  - 4 cycles per frame.
